logic_unit: RTL and testbench
=============================

// Module: logic_unit
// PURPOSE
//  16-bit bitwise logic and compare unit for the controller datapath.
//  Applies one of eight opcode-selected bitwise operations to operands a and b.
//  Returns a 32-bit result plus zero and magnitude-compare flags.
//  All outputs are registered on clk, with one cycle of latency.
// PARAMETERS
//  none (widths fixed: operands 16 b, result 32 b, opcode 3 b)
// PORTS
//  clk     in   1   system clock; all state updates on its rising edge
//  rst     in   1   asynchronous, active-high reset
//  a       in   16  operand A (unsigned)
//  b       in   16  operand B (unsigned)
//  opcode  in   3   operation select, see BEHAVIOUR
//  outlu   out  32  registered operation result
//  za      out  1   registered: a == 0
//  zb      out  1   registered: b == 0
//  eq      out  1   registered: a == b
//  gt      out  1   registered: a > b (unsigned)
//  lt      out  1   registered: a < b (unsigned)
// BEHAVIOUR
//  - Reset: rst high clears outlu, za, zb, eq, gt and lt to 0 immediately, with no clock needed.
//    They stay 0 while rst is high. The first capture happens on the first rising clk edge after rst falls.
//  - Latency: a, b and opcode are sampled on each rising clk edge.
//    Results and flags for those samples appear right after that edge and hold until the next edge.
//  - There is no handshake or enable: the unit captures a new result every cycle.
//  - opcode map. 16-bit results are zero-extended into outlu[31:16]:
//      000  a & b
//      001  a | b
//      010  a ^ b
//      011  ~(a & b)
//      100  ~(a | b)
//      101  ~(a ^ b)
//      110  ~a           (b is ignored)
//      111  {a, b}       (a in [31:16], b in [15:0])
//  - The flags are computed from a and b every cycle, whatever the opcode.
//    Exactly one of eq, gt, lt is 1 after reset is released.
//  - za and zb are independent: both are 1 when a = b = 0, and eq is 1 in that case too.
//  - Only rising edges of rst/clk change the outputs.
//    A change on opcode alone has no effect until the next clk edge.
//  - Reset asserted in the middle of operation discards the pending result.
//    No stale value appears after reset is released.
// TESTING
//  1. Reset: rst=1 with a=0x0009, b=0x0005 -> all outputs 0.
//     Release rst; after 1 clk: gt=1, eq=lt=za=zb=0.
//  2. a=0x0009, b=0x0005, opcode swept 000..111, one value per clk
//     -> outlu = 0x00000001, 0x0000000D, 0x0000000C, 0x0000FFFE,
//        0x0000FFF2, 0x0000FFF3, 0x0000FFF6, 0x00090005
//     -> gt=1 throughout.
//  3. a=0x0003, b=0x000F, opcodes 000/001/010/110/111
//     -> outlu = 0x00000003, 0x0000000F, 0x0000000C, 0x0000FFFC, 0x0003000F
//     -> lt=1, gt=eq=0.
//  4. a=b=0x00E9, opcodes 010/101/111
//     -> outlu = 0x00000000, 0x0000FFFF, 0x00E900E9
//     -> eq=1, gt=lt=0.
//  5. a=0x0000, b=0x00E9 -> za=1, zb=0, lt=1.
//     Then b=0x0000 -> za=zb=eq=1, outlu(opcode 011)=0x0000FFFF.
//  6. Assert rst mid-sweep between clk edges -> outputs drop to 0 at once, without waiting for clk.
//     Release rst; the next edge gives correct values again.

Source files
------------

// File: rtl/logic_unit.sv
// 16-bit bitwise logic and compare unit with registered result and flags.
// One cycle of latency; async active-high reset clears every output.
module logic_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  opcode,
    output logic [31:0] outlu,
    output logic        za,
    output logic        zb,
    output logic        eq,
    output logic        gt,
    output logic        lt
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_CAT  = 3'b111
    } op_e;

    op_e         op;
    logic [31:0] outlu_d, outlu_q;
    logic        za_d, za_q;
    logic        zb_d, zb_q;
    logic        eq_d, eq_q;
    logic        gt_d, gt_q;
    logic        lt_d, lt_q;

    assign op = op_e'(opcode);

    // 16-bit ops zero-extend; only concatenation fills the upper half
    always_comb begin
        outlu_d = 32'h0;
        unique case (op)
            OP_AND:  outlu_d = {16'h0, a & b};
            OP_OR:   outlu_d = {16'h0, a | b};
            OP_XOR:  outlu_d = {16'h0, a ^ b};
            OP_NAND: outlu_d = {16'h0, ~(a & b)};
            OP_NOR:  outlu_d = {16'h0, ~(a | b)};
            OP_XNOR: outlu_d = {16'h0, ~(a ^ b)};
            OP_NOTA: outlu_d = {16'h0, ~a};
            OP_CAT:  outlu_d = {a, b};
            default: outlu_d = 32'h0;
        endcase
    end

    always_comb begin
        za_d = (a == 16'h0);
        zb_d = (b == 16'h0);
        eq_d = (a == b);
        gt_d = (a > b);
        lt_d = (a < b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outlu_q <= 32'h0;
            za_q    <= 1'b0;
            zb_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            outlu_q <= outlu_d;
            za_q    <= za_d;
            zb_q    <= zb_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign outlu = outlu_q;
    assign za    = za_q;
    assign zb    = zb_q;
    assign eq    = eq_q;
    assign gt    = gt_q;
    assign lt    = lt_q;

endmodule

// File: tb/tb_logic_unit.sv
// Directed testbench for logic_unit with hand-computed expectations.
module tb_logic_unit;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  opcode;
    logic [31:0] outlu;
    logic        za, zb, eq, gt, lt;

    int n_pass;
    int n_total;

    logic [31:0] exp_tab2 [8];

    logic [4:0] FL_GT, FL_LT, FL_EQ, FL_0;

    logic_unit dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .outlu  (outlu),
        .za     (za),
        .zb     (zb),
        .eq     (eq),
        .gt     (gt),
        .lt     (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {27'h0, za, zb, eq, gt, lt};
    endfunction

    // apply inputs, clock once, sample 1 time unit after the edge
    task automatic step(input logic [15:0] va,
                        input logic [15:0] vb,
                        input logic [2:0]  vop);
        a      = va;
        b      = vb;
        opcode = vop;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        FL_GT = 5'b00010;
        FL_LT = 5'b00001;
        FL_EQ = 5'b00100;
        FL_0  = 5'b00000;
        exp_tab2[0] = 32'h0000_0001;
        exp_tab2[1] = 32'h0000_000D;
        exp_tab2[2] = 32'h0000_000C;
        exp_tab2[3] = 32'h0000_FFFE;
        exp_tab2[4] = 32'h0000_FFF2;
        exp_tab2[5] = 32'h0000_FFF3;
        exp_tab2[6] = 32'h0000_FFF6;
        exp_tab2[7] = 32'h0009_0005;

        // 1. reset
        rst    = 1'b1;
        a      = 16'h0009;
        b      = 16'h0005;
        opcode = 3'b000;
        #2;
        check("rst_outlu", outlu, 32'h0);
        check("rst_flags", flags(), {27'h0, FL_0});
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_outlu", outlu, 32'h0);
        check("rst_hold_flags", flags(), {27'h0, FL_0});
        @(negedge clk);
        rst = 1'b0;
        step(16'h0009, 16'h0005, 3'b000);
        check("rel_flags", flags(), {27'h0, FL_GT});
        check("rel_outlu", outlu, 32'h0000_0001);

        // 2. full opcode sweep
        for (int i = 0; i < 8; i++) begin
            step(16'h0009, 16'h0005, 3'(i));
            check($sformatf("sweep_op%0d", i), outlu, exp_tab2[i]);
            check($sformatf("sweep_gt%0d", i), flags(),
                  {27'h0, FL_GT});
        end

        // opcode change alone must not move outputs between edges
        opcode = 3'b000;
        #2;
        check("op_only_hold", outlu, 32'h0009_0005);

        // 3. a < b
        step(16'h0003, 16'h000F, 3'b000);
        check("lt_and", outlu, 32'h0000_0003);
        check("lt_flags", flags(), {27'h0, FL_LT});
        step(16'h0003, 16'h000F, 3'b001);
        check("lt_or", outlu, 32'h0000_000F);
        step(16'h0003, 16'h000F, 3'b010);
        check("lt_xor", outlu, 32'h0000_000C);
        step(16'h0003, 16'h000F, 3'b110);
        check("lt_nota", outlu, 32'h0000_FFFC);
        step(16'h0003, 16'h000F, 3'b111);
        check("lt_cat", outlu, 32'h0003_000F);
        check("lt_flags2", flags(), {27'h0, FL_LT});

        // 4. a == b
        step(16'h00E9, 16'h00E9, 3'b010);
        check("eq_xor", outlu, 32'h0000_0000);
        check("eq_flags", flags(), {27'h0, FL_EQ});
        step(16'h00E9, 16'h00E9, 3'b101);
        check("eq_xnor", outlu, 32'h0000_FFFF);
        step(16'h00E9, 16'h00E9, 3'b111);
        check("eq_cat", outlu, 32'h00E9_00E9);

        // 5. zero operands
        step(16'h0000, 16'h00E9, 3'b000);
        check("za_flags", flags(), {27'h0, 5'b10001});
        step(16'h0000, 16'h0000, 3'b011);
        check("zz_flags", flags(), {27'h0, 5'b11100});
        check("zz_nand", outlu, 32'h0000_FFFF);

        // 6. reset mid-sweep, between edges
        step(16'h0009, 16'h0005, 3'b001);
        check("pre_rst_or", outlu, 32'h0000_000D);
        a      = 16'h0003;
        b      = 16'h000F;
        opcode = 3'b111;
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_outlu", outlu, 32'h0);
        check("mid_rst_flags", flags(), {27'h0, FL_0});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel2_hold", outlu, 32'h0);
        step(16'h0009, 16'h0005, 3'b010);
        check("rel2_xor", outlu, 32'h0000_000C);
        check("rel2_flags", flags(), {27'h0, FL_GT});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
